// File: rtl/fft_pkg.sv
// Shared types and default geometry for the in-place radix-2 FFT controller.
package fft_pkg;

    localparam int LOG2N_DEF  = 4;
    localparam int RD_LAT_DEF = 1;
    localparam int BF_LAT_DEF = 2;

    // Cycles from issuing a read to writing its butterfly result back.
    function automatic int drain_len(input int rd_lat, input int bf_lat);
        return rd_lat + bf_lat;
    endfunction

    localparam int D_DEF = drain_len(RD_LAT_DEF, BF_LAT_DEF);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/fft_agu.sv
// Butterfly address generator: maps (stage, k) to operand and twiddle addresses.
module fft_agu #(
    parameter int LOG2N = 4,
    parameter int SW    = 2
) (
    input  logic [SW-1:0]    stage,
    input  logic [LOG2N-2:0] k,
    output logic [LOG2N-1:0] addr_a,
    output logic [LOG2N-1:0] addr_b,
    output logic [LOG2N-2:0] tw_addr
);

    localparam int KW = LOG2N - 1;
    localparam logic [KW-1:0]    K_ONE = KW'(1);
    localparam logic [LOG2N-1:0] A_ONE = LOG2N'(1);
    localparam logic [SW-1:0]    S_MAX = SW'(LOG2N - 1);

    logic [KW-1:0] mask;
    logic [KW-1:0] pos;

    // k splits into group (high bits) and pos (low 'stage' bits); the group
    // bits move up one place to leave room for the half-span offset.
    always_comb begin
        mask    = (K_ONE << stage) - K_ONE;
        pos     = k & mask;
        addr_a  = ({1'b0, k & ~mask} << 1) | {1'b0, pos};
        addr_b  = addr_a | (A_ONE << stage);
        tw_addr = pos << (S_MAX - stage);
    end

endmodule

// File: rtl/fft_ctrl.sv
// Sequencer for an in-place radix-2 FFT: issues butterfly reads per stage and
// replays them as writes after the memory + butterfly latency.
module fft_ctrl
    import fft_pkg::*;
#(
    parameter int LOG2N  = LOG2N_DEF,
    parameter int RD_LAT = RD_LAT_DEF,
    parameter int BF_LAT = BF_LAT_DEF,
    localparam int SW    = (LOG2N > 1) ? $clog2(LOG2N) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             rd_en,
    output logic [LOG2N-1:0] rd_addr_a,
    output logic [LOG2N-1:0] rd_addr_b,
    output logic [LOG2N-2:0] tw_addr,
    output logic             wr_en,
    output logic [LOG2N-1:0] wr_addr_a,
    output logic [LOG2N-1:0] wr_addr_b,
    output logic [SW-1:0]    stage,
    output state_t           fsm_state
);

    localparam int N  = 1 << LOG2N;
    localparam int D  = drain_len(RD_LAT, BF_LAT);
    localparam int KW = LOG2N - 1;
    localparam int CW = (D > 1) ? $clog2(D) : 1;

    localparam logic [KW-1:0] K_LAST = KW'(N / 2 - 1);
    localparam logic [SW-1:0] S_LAST = SW'(LOG2N - 1);
    localparam logic [CW-1:0] C_LAST = CW'(D - 1);

    state_t        state;
    logic [KW-1:0] k;
    logic [CW-1:0] drain_cnt;

    logic [LOG2N-1:0] agu_a;
    logic [LOG2N-1:0] agu_b;
    logic [LOG2N-2:0] agu_tw;

    logic             pipe_en [D];
    logic [LOG2N-1:0] pipe_a  [D];
    logic [LOG2N-1:0] pipe_b  [D];

    fft_agu #(
        .LOG2N (LOG2N),
        .SW    (SW)
    ) u_agu (
        .stage   (stage),
        .k       (k),
        .addr_a  (agu_a),
        .addr_b  (agu_b),
        .tw_addr (agu_tw)
    );

    // Addresses are held at zero whenever no read is being issued.
    assign rd_addr_a = rd_en ? agu_a  : '0;
    assign rd_addr_b = rd_en ? agu_b  : '0;
    assign tw_addr   = rd_en ? agu_tw : '0;
    assign fsm_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            stage     <= '0;
            k         <= '0;
            drain_cnt <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rd_en     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_RUN;
                        stage <= '0;
                        k     <= '0;
                        busy  <= 1'b1;
                        rd_en <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (k == K_LAST) begin
                        state     <= ST_DRAIN;
                        drain_cnt <= '0;
                        rd_en     <= 1'b0;
                    end else begin
                        k <= k + KW'(1);
                    end
                end
                // Hold off the next stage until every result of this one is written.
                ST_DRAIN: begin
                    if (drain_cnt == C_LAST) begin
                        if (stage == S_LAST) begin
                            state <= ST_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_RUN;
                            stage <= stage + SW'(1);
                            k     <= '0;
                            rd_en <= 1'b1;
                        end
                    end else begin
                        drain_cnt <= drain_cnt + CW'(1);
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    done  <= 1'b0;
                    stage <= '0;
                    k     <= '0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < D; i++) begin
                pipe_en[i] <= 1'b0;
                pipe_a[i]  <= '0;
                pipe_b[i]  <= '0;
            end
        end else begin
            pipe_en[0] <= rd_en;
            pipe_a[0]  <= rd_addr_a;
            pipe_b[0]  <= rd_addr_b;
            for (int i = 1; i < D; i++) begin
                pipe_en[i] <= pipe_en[i-1];
                pipe_a[i]  <= pipe_a[i-1];
                pipe_b[i]  <= pipe_b[i-1];
            end
        end
    end

    assign wr_en     = pipe_en[D-1];
    assign wr_addr_a = pipe_a[D-1];
    assign wr_addr_b = pipe_b[D-1];

endmodule

// File: tb/tb_fft_ctrl.sv
// Directed bench for fft_ctrl at default geometry (N=16, D=3) with a
// write-address scoreboard fed from a cycle-count model of the schedule.
module tb_fft_ctrl;
    import fft_pkg::*;

    localparam int LOG2N   = 4;
    localparam int N       = 16;
    localparam int D       = 3;
    localparam int RUN_LEN = N / 2 + D;
    localparam int TOTAL   = LOG2N * RUN_LEN + 1;

    typedef struct packed {
        logic [31:0] due;
        logic [1:0]  stg;
        logic [3:0]  a;
        logic [3:0]  b;
    } wr_t;

    logic       clk;
    logic       rst;
    logic       start;
    logic       busy;
    logic       done;
    logic       rd_en;
    logic [3:0] rd_addr_a;
    logic [3:0] rd_addr_b;
    logic [2:0] tw_addr;
    logic       wr_en;
    logic [3:0] wr_addr_a;
    logic [3:0] wr_addr_b;
    logic [1:0] stage;
    state_t     fsm_state;

    wr_t exp_q[$];
    int  n_cmp;
    int  n_fail;
    int  cyc;
    int  run_t;
    int  wcount[4][16];

    fft_ctrl #(
        .LOG2N  (4),
        .RD_LAT (1),
        .BF_LAT (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .rd_en     (rd_en),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .tw_addr   (tw_addr),
        .wr_en     (wr_en),
        .wr_addr_a (wr_addr_a),
        .wr_addr_b (wr_addr_b),
        .stage     (stage),
        .fsm_state (fsm_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv)
        else begin
            n_fail++;
            $error("FAIL %s cycle %0d: observed %0d expected %0d", tag, cyc, obs, expv);
        end
    endtask

    // Expected outputs for the current cycle from the fixed schedule:
    // LOG2N stages of (N/2 reads + D drain cycles), then one DONE cycle.
    task automatic check_cycle();
        logic exp_busy, exp_done, exp_rd, exp_wr;
        int   s, w, half, pos, grp, ea, eb, etw;
        wr_t  e;
        exp_busy = (run_t >= 1) && (run_t <= TOTAL - 1);
        exp_done = (run_t == TOTAL);
        exp_rd   = 1'b0;
        s = 0;
        w = 0;
        if (exp_busy) begin
            s      = (run_t - 1) / RUN_LEN;
            w      = (run_t - 1) % RUN_LEN;
            exp_rd = (w < N / 2);
        end
        chk("busy", busy, exp_busy);
        chk("done", done, exp_done);
        chk("rd_en", rd_en, exp_rd);
        if (exp_busy) chk("stage", stage, s);
        if (exp_rd) begin
            half = 1 << s;
            pos  = w % half;
            grp  = w / half;
            ea   = 2 * half * grp + pos;
            eb   = ea + half;
            etw  = pos << (LOG2N - 1 - s);
            chk("rd_addr_a", rd_addr_a, ea);
            chk("rd_addr_b", rd_addr_b, eb);
            chk("tw_addr", tw_addr, etw);
            e.due = cyc + D;
            e.stg = s[1:0];
            e.a   = ea[3:0];
            e.b   = eb[3:0];
            exp_q.push_back(e);
        end
        exp_wr = (exp_q.size() > 0) && (exp_q[0].due == cyc);
        chk("wr_en", wr_en, exp_wr);
        if (exp_wr) begin
            e = exp_q.pop_front();
            if (wr_en === 1'b1) begin
                chk("wr_addr_a", wr_addr_a, e.a);
                chk("wr_addr_b", wr_addr_b, e.b);
                if (!$isunknown({wr_addr_a, wr_addr_b})) begin
                    wcount[e.stg][wr_addr_a]++;
                    wcount[e.stg][wr_addr_b]++;
                end
            end
        end
    endtask

    // Drive inputs for the current cycle, clock once, then check the next cycle.
    task automatic tick(input logic st, input logic r);
        start = st;
        rst   = r;
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (r) begin
            run_t = -1;
            exp_q.delete();
        end else if (run_t >= 1 && run_t < TOTAL) begin
            run_t++;
        end else if (run_t == TOTAL) begin
            run_t = -1;
        end else if (st) begin
            run_t = 1;
        end
        check_cycle();
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        cyc    = 0;
        run_t  = -1;
        rst    = 1'b1;
        start  = 1'b0;
        @(negedge clk);

        // Reset state
        tick(1'b0, 1'b1);
        tick(1'b1, 1'b1);
        chk("rst_state", fsm_state, ST_IDLE);
        chk("rst_addr_a", rd_addr_a, 0);
        chk("rst_addr_b", rd_addr_b, 0);
        chk("rst_wr_addr_b", wr_addr_b, 0);
        repeat ($urandom_range(2, 5)) tick(1'b0, 1'b0);

        // Single full transform from a one-cycle start pulse
        for (int st = 0; st < 4; st++)
            for (int ad = 0; ad < 16; ad++) wcount[st][ad] = 0;
        cyc = 0;
        tick(1'b1, 1'b0);
        while (cyc < 50) begin
            case (cyc)
                1: begin
                    chk("s0k0_a", rd_addr_a, 0);
                    chk("s0k0_b", rd_addr_b, 1);
                    chk("s0k0_tw", tw_addr, 0);
                end
                4: begin
                    chk("s0k3_a", rd_addr_a, 6);
                    chk("s0k3_b", rd_addr_b, 7);
                    chk("s0k3_tw", tw_addr, 0);
                end
                28: begin
                    chk("s2k5_a", rd_addr_a, 9);
                    chk("s2k5_b", rd_addr_b, 13);
                    chk("s2k5_tw", tw_addr, 2);
                end
                41: begin
                    chk("s3k7_a", rd_addr_a, 7);
                    chk("s3k7_b", rd_addr_b, 15);
                    chk("s3k7_tw", tw_addr, 7);
                end
                45: chk("done_state", fsm_state, ST_DONE);
                default: ;
            endcase
            tick(1'b0, 1'b0);
        end
        chk("q_empty_run1", exp_q.size(), 0);
        for (int st = 0; st < 4; st++)
            for (int ad = 0; ad < 16; ad++) chk("write_once", wcount[st][ad], 1);
        repeat ($urandom_range(2, 5)) tick(1'b0, 1'b0);

        // Start held high: the second transform waits for IDLE
        cyc = 0;
        tick(1'b1, 1'b0);
        while (cyc < 60) begin
            if (cyc == 46) chk("held_gap_rd", rd_en, 0);
            if (cyc == 47) chk("held_restart_rd", rd_en, 1);
            tick(1'b1, 1'b0);
        end
        while (cyc < 100) tick(1'b0, 1'b0);
        chk("q_empty_run2", exp_q.size(), 0);
        repeat ($urandom_range(2, 5)) tick(1'b0, 1'b0);

        // Reset mid-transform, then a clean restart
        cyc = 0;
        tick(1'b1, 1'b0);
        while (cyc < 20) tick(1'b0, 1'b0);
        tick(1'b0, 1'b1);
        chk("abort_busy", busy, 0);
        chk("abort_wr_en", wr_en, 0);
        chk("abort_wr_addr_a", wr_addr_a, 0);
        chk("abort_stage", stage, 0);
        chk("abort_state", fsm_state, ST_IDLE);
        while (cyc < 25) tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        while (cyc < 75) begin
            if (cyc == 70) chk("restart_done", done, 1);
            tick(1'b0, 1'b0);
        end
        chk("q_empty_run3", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fft_ctrl.md
FFT_CTRL -- requirements
Module: fft_ctrl

Interface
REQ-001 SHALL have parameter LOG2N, default 4, giving log2 of the transform size N (N = 2^LOG2N points).
REQ-002 SHALL have parameter RD_LAT, default 1, giving the data-memory read latency in cycles.
REQ-003 SHALL have parameter BF_LAT, default 2, giving the butterfly latency in cycles (multiplier register plus output register).
REQ-004 clk  input  1  single clock; all logic is on its rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 start  input  1  begins one in-place FFT when sampled high in IDLE.
REQ-007 busy  output  1  high while a transform is in progress.
REQ-008 done  output  1  one-cycle pulse when the transform completes.
REQ-009 rd_en  output  1  read strobe for the operand pair.
REQ-010 rd_addr_a, rd_addr_b  output  LOG2N  addresses of butterfly inputs a and b.
REQ-011 tw_addr  output  LOG2N-1  twiddle ROM index for the current butterfly.
REQ-012 wr_en  output  1  write strobe for the butterfly result pair.
REQ-013 wr_addr_a, wr_addr_b  output  LOG2N  destinations of y0 and y1.
REQ-014 stage  output  ceil(log2(LOG2N))  current stage index, 0 to LOG2N-1.

Function
REQ-015 SHALL implement states IDLE, RUN, DRAIN, DONE.
REQ-016 IDLE -> RUN when start=1; stage=0 and butterfly counter k=0 on entry.
REQ-017 In RUN, SHALL issue one butterfly per cycle, with rd_en=1 and k incrementing from 0 to N/2-1.
REQ-018 Addressing: half=2^stage, pos=k mod half, group=k/half; rd_addr_a=2*half*group+pos; rd_addr_b=rd_addr_a+half; tw_addr=pos<<(LOG2N-1-stage).
REQ-019 RUN -> DRAIN after issuing k=N/2-1; rd_en=0 in DRAIN.
REQ-020 wr_en, wr_addr_a and wr_addr_b SHALL equal rd_en, rd_addr_a and rd_addr_b delayed by exactly D=RD_LAT+BF_LAT cycles.
REQ-021 DRAIN SHALL last D cycles so that the last write of a stage precedes the first read of the next stage (no read-after-write hazard).
REQ-022 DRAIN -> RUN with stage+1 and k=0 if stage<LOG2N-1; otherwise DRAIN -> DONE.
REQ-023 DONE SHALL assert done for one cycle and deassert busy in that same cycle, then go to IDLE.
REQ-024 busy SHALL be high in RUN and DRAIN only; start SHALL be ignored while busy or in DONE.
REQ-025 Total latency: first rd_en one cycle after start is sampled; done exactly LOG2N*(N/2+D)+1 cycles after start (45 for defaults).
REQ-026 Address arithmetic SHALL be unsigned LOG2N-bit with no wrap; rd_addr_b never exceeds N-1.

Reset
REQ-027 rst SHALL force IDLE, stage=0, k=0, and busy, done, rd_en and wr_en to 0 on the next edge, and SHALL clear the write-delay pipeline.
REQ-028 rst asserted mid-transform SHALL abort it, with no further wr_en pulses; all address outputs reset to 0.

Structure
REQ-029 Shared package fft_pkg SHALL hold the state enum, the defaults for LOG2N, RD_LAT and BF_LAT, and the derived constant D.
REQ-030 Sub-module fft_agu SHALL compute rd_addr_a, rd_addr_b and tw_addr from (stage, k) combinationally; the delay line and FSM live in fft_ctrl.

Verification (defaults: N=16, D=3)
REQ-031 start pulse at cycle 0 -> rd_en high on cycles 1-8; stage 0 k=0 gives a=0, b=1, tw=0; k=3 gives a=6, b=7, tw=0.
REQ-032 Stage 2, k=5 -> rd_addr_a=9, rd_addr_b=13, tw_addr=2; stage 3, k=7 -> a=7, b=15, tw=7.
REQ-033 Full run -> wr_en high on cycles 4-11, 15-22, 26-33 and 37-44; done high only on cycle 45; busy high on cycles 1-44.
REQ-034 start held high throughout -> second transform begins only after IDLE is re-entered (first rd_en on cycle 47); no overlap.
REQ-035 rst asserted on cycle 20 -> from cycle 21, busy=0, wr_en=0 and no done pulse; a start on cycle 25 gives a normal 45-cycle run.
REQ-036 Scoreboard: over one run, every address 0-15 is written exactly once per stage, and the write addresses match the read addresses issued 3 cycles earlier.
